// File: rtl/ks_xor_stream.sv
// Keystream XOR stream: holds one 512-bit keystream block and XORs it byte by byte onto plaintext.
// Optional feature: define KSX_BYTE_CNT_EN to add the byte_cnt output (ciphertext handshake counter).
module ks_xor_stream (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] ks_block,
    input  logic [11:0]  ks_len,
    input  logic         ks_valid,
    output logic         ks_ready,
    input  logic [7:0]   pt_data,
    input  logic         pt_valid,
    output logic         pt_ready,
    output logic [7:0]   ct_data,
    output logic         ct_valid,
    input  logic         ct_ready,
`ifdef KSX_BYTE_CNT_EN
    output logic [31:0]  byte_cnt,
`endif
    output logic         busy
);

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [511:0] ks_q, ks_d;
    logic [6:0]   idx_q, idx_d;
    logic [6:0]   nbytes_q, nbytes_d;
    logic [7:0]   tail_mask_q, tail_mask_d;
    logic         ct_valid_q, ct_valid_d;
    logic [7:0]   ct_data_q, ct_data_d;

    logic [9:0]   eff_len;
    logic [6:0]   nbytes_new;
    logic [7:0]   tail_mask_new;
    logic         last_byte;
    logic [7:0]   ks_byte;
    logic         ks_fire;
    logic         pt_fire;
    logic         ct_fire;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid/data
    // are held by the source until accepted, and ready never depends on the same-side valid.
    assign ks_ready = (state_q == EMPTY);
    assign pt_ready = (state_q == ACTIVE) && (!ct_valid_q || ct_ready);
    assign busy     = (state_q == ACTIVE);
    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;

    assign ks_fire = ks_valid && ks_ready;
    assign pt_fire = pt_valid && pt_ready;
    assign ct_fire = ct_valid_q && ct_ready;

    // Lengths above one block saturate to 512 bits.
    assign eff_len       = (ks_len > 12'd512) ? 10'd512 : ks_len[9:0];
    assign nbytes_new    = 7'((eff_len + 10'd7) >> 3);
    assign tail_mask_new = (eff_len[2:0] == 3'd0) ? 8'hFF : ~(8'hFF >> eff_len[2:0]);

    // The held block is shifted left per byte, so the current byte is always the top one.
    assign last_byte = (idx_q == (nbytes_q - 7'd1));
    assign ks_byte   = ks_q[511:504] & (last_byte ? tail_mask_q : 8'hFF);

    always_comb begin
        state_d     = state_q;
        ks_d        = ks_q;
        idx_d       = idx_q;
        nbytes_d    = nbytes_q;
        tail_mask_d = tail_mask_q;
        ct_valid_d  = ct_valid_q;
        ct_data_d   = ct_data_q;

        case (state_q)
            EMPTY: begin
                if (ks_fire && (ks_len != 12'd0)) begin
                    ks_d        = ks_block;
                    nbytes_d    = nbytes_new;
                    idx_d       = 7'd0;
                    tail_mask_d = tail_mask_new;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pt_fire) begin
                    ks_d  = {ks_q[503:0], 8'h00};
                    idx_d = idx_q + 7'd1;
                    if (last_byte) begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        if (pt_fire) begin
            ct_valid_d = 1'b1;
            ct_data_d  = pt_data ^ ks_byte;
        end else if (ct_fire) begin
            ct_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            ks_q        <= '0;
            idx_q       <= '0;
            nbytes_q    <= '0;
            tail_mask_q <= '0;
            ct_valid_q  <= 1'b0;
            ct_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ks_q        <= ks_d;
            idx_q       <= idx_d;
            nbytes_q    <= nbytes_d;
            tail_mask_q <= tail_mask_d;
            ct_valid_q  <= ct_valid_d;
            ct_data_q   <= ct_data_d;
        end
    end

`ifdef KSX_BYTE_CNT_EN
    logic [31:0] byte_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
        end else if (ct_fire) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
        end
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_ks_xor_stream.sv
// Directed bench for ks_xor_stream with a scoreboard of expected ciphertext bytes.
// Define KSX_BYTE_CNT_EN to also exercise the byte counter.
module tb_ks_xor_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] ks_block;
    logic [11:0]  ks_len;
    logic         ks_valid;
    logic         ks_ready;
    logic [7:0]   pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic [7:0]   ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic         busy;
`ifdef KSX_BYTE_CNT_EN
    logic [31:0]  byte_cnt;
`endif

    always #5 clk = ~clk;

    ks_xor_stream dut (
        .clk      (clk),
        .reset    (reset),
        .ks_block (ks_block),
        .ks_len   (ks_len),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .pt_data  (pt_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
`ifdef KSX_BYTE_CNT_EN
        .byte_cnt (byte_cnt),
`endif
        .busy     (busy)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           n_ct_fires = 0;
    logic [7:0]   exp_q[$];

    logic [511:0] m_blk;
    int           m_len;
    int           m_k;
    logic [511:0] blk;
    logic [7:0]   e0;
    logic [7:0]   kb;
    int           c0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference keystream byte, built bit by bit from the block and its length.
    function automatic logic [7:0] ks_model(input logic [511:0] b, input int len, input int k);
        int         eff;
        logic [7:0] r;
        eff = (len > 512) ? 512 : len;
        r   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (8 * k + i < eff) r[7 - i] = b[511 - 8 * k - i];
        end
        return r;
    endfunction

    // Scoreboard side: every ciphertext handshake pops one expected byte.
    always @(negedge clk) begin
        if (reset) begin
            n_ct_fires = 0;
        end else if (ct_valid && ct_ready) begin
            n_ct_fires++;
            if (exp_q.size() == 0) check("ct_unexpected", exp_q.size(), 1);
            else check("ct_data", {24'h0, ct_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[i * 32 +: 32] = $urandom;
    endtask

    task automatic send_ks(input logic [511:0] b, input logic [11:0] len);
        int t = 0;
        ks_block = b;
        ks_len   = len;
        ks_valid = 1'b1;
        @(negedge clk);
        while (!ks_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("ks_accept", {31'h0, ks_ready}, 32'h1);
        tick();
        ks_valid = 1'b0;
        m_blk = b;
        m_len = int'(len);
        m_k   = 0;
    endtask

    task automatic send_pt(input logic [7:0] d, input logic [7:0] e);
        int t = 0;
        pt_data  = d;
        pt_valid = 1'b1;
        @(negedge clk);
        while (!pt_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("pt_accept", {31'h0, pt_ready}, 32'h1);
        if (pt_ready) exp_q.push_back(e);
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] d);
        send_pt(d, d ^ ks_model(m_blk, m_len, m_k));
        m_k++;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        ks_block = '0;
        ks_len   = '0;
        ks_valid = 1'b0;
        pt_data  = '0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ks_ready", {31'h0, ks_ready}, 32'h1);
        check("rst_pt_ready", {31'h0, pt_ready}, 32'h0);
        check("rst_ct_valid", {31'h0, ct_valid}, 32'h0);
        check("rst_ct_data", {24'h0, ct_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Full block, counting pattern, one byte per cycle.
        blk = '0;
        for (int k = 0; k < 64; k++) blk[511 - 8 * k -: 8] = 8'(k);
        send_ks(blk, 12'd512);
        check("full_busy", {31'h0, busy}, 32'h1);
        c0 = cyc;
        for (int k = 0; k < 64; k++) begin
            kb = 8'(k);
            send_pt(8'hFF, 8'hFF ^ kb);
        end
        check("full_rate", cyc - c0, 64);
        check("full_ks_ready", {31'h0, ks_ready}, 32'h1);
        drain();

        // Partial length of 12 bits.
        rand_block(blk);
        blk[511:496] = 16'hABCD;
        send_ks(blk, 12'd12);
        send_pt(8'h00, 8'hAB);
        send_pt(8'h00, 8'hC0);
        check("part_busy", {31'h0, busy}, 32'h0);
        check("part_ks_ready", {31'h0, ks_ready}, 32'h1);
        drain();

        // Backpressure after the first byte.
        rand_block(blk);
        send_ks(blk, 12'd512);
        pt_data = 8'($urandom);
        e0 = pt_data ^ ks_model(m_blk, m_len, m_k);
        send_model(pt_data);
        ct_ready = 1'b0;
        pt_data  = 8'($urandom);
        pt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ct_valid", {31'h0, ct_valid}, 32'h1);
            check("bp_ct_data", {24'h0, ct_data}, {24'h0, e0});
            check("bp_pt_ready", {31'h0, pt_ready}, 32'h0);
            tick();
        end
        ct_ready = 1'b1;
        for (int i = 1; i < 64; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                ct_ready = 1'b0;
                tick();
                ct_ready = 1'b1;
            end
            send_model(8'($urandom));
        end
        drain();

        // Zero length is discarded.
        rand_block(blk);
        send_ks(blk, 12'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("zero_ks_ready", {31'h0, ks_ready}, 32'h1);
            check("zero_busy", {31'h0, busy}, 32'h0);
            check("zero_ct_valid", {31'h0, ct_valid}, 32'h0);
            tick();
        end

        // Oversized length saturates to 64 bytes; new blocks ignored while active.
        rand_block(blk);
        send_ks(blk, 12'd4000);
        rand_block(ks_block);
        ks_len   = 12'd512;
        ks_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("active_ks_ready", {31'h0, ks_ready}, 32'h0);
            tick();
        end
        ks_valid = 1'b0;
        for (int i = 0; i < 64; i++) send_model(8'($urandom));
        check("big_busy", {31'h0, busy}, 32'h0);
        pt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("big_no_extra", {31'h0, pt_ready}, 32'h0);
            tick();
        end
        pt_valid = 1'b0;
        drain();

        // Reset after byte 10, with byte 10 still pending.
        rand_block(blk);
        send_ks(blk, 12'd512);
        for (int i = 0; i < 10; i++) send_model(8'($urandom));
        ct_ready = 1'b0;
        reset    = 1'b1;
        tick();
        check("mid_rst_ct_valid", {31'h0, ct_valid}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ks_ready", {31'h0, ks_ready}, 32'h1);
        check("mid_rst_pt_ready", {31'h0, pt_ready}, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        ct_ready = 1'b1;
        tick();
        rand_block(blk);
        send_ks(blk, 12'd512);
        for (int i = 0; i < 4; i++) send_model(8'($urandom));
        drain();

`ifdef KSX_BYTE_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("cnt_reset", byte_cnt, 32'h0);
        for (int b = 0; b < 2; b++) begin
            rand_block(blk);
            send_ks(blk, 12'd512);
            for (int i = 0; i < 64; i++) send_model(8'($urandom));
        end
        drain();
        tick();
        check("cnt_two_blocks", byte_cnt, 32'd128);
        check("cnt_model", byte_cnt, 32'(n_ct_fires));
        force dut.byte_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.byte_cnt_q;
        rand_block(blk);
        send_ks(blk, 12'd8);
        send_model(8'($urandom));
        drain();
        tick();
        check("cnt_wrap", byte_cnt, 32'h0);
`endif

        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ks_xor_stream.md
KS_XOR_STREAM -- requirements
Module: ks_xor_stream

Interface
REQ-001 The block SHALL have no parameters; block width is fixed at 512 bits and byte width at 8 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 ks_block  input  512  keystream block from the cipher core; bit 511 is the first keystream bit.
REQ-005 ks_len  input  12  number of valid keystream bits in ks_block, sampled with the block.
REQ-006 ks_valid  input  1  ks_block and ks_len valid.
REQ-007 ks_ready  output  1  block accepted on a cycle with ks_valid && ks_ready.
REQ-008 pt_data  input  8  plaintext byte; bit 7 pairs with the earlier keystream bit.
REQ-009 pt_valid / pt_ready  input / output  1 each  plaintext handshake.
REQ-010 ct_data  output  8  ciphertext byte.
REQ-011 ct_valid / ct_ready  output / input  1 each  ciphertext handshake.
REQ-012 busy  output  1  high while a keystream block is held.

Function
REQ-013 The block SHALL implement FSM states EMPTY and ACTIVE; ks_ready = (state == EMPTY).
REQ-014 On a ks handshake the block SHALL latch ks_block and set nbytes = ceil(min(ks_len, 512) / 8), with idx = 0.
REQ-015 If ks_len == 0, the block SHALL stay EMPTY and discard the block.
REQ-016 If ks_len > 512, the block SHALL treat it as 512, giving 64 bytes.
REQ-017 If ks_len >= 1, the block SHALL go ACTIVE.
REQ-018 Keystream byte k SHALL be ks_block[511-8k -: 8].
REQ-019 For the last byte with r = ks_len mod 8, r != 0, only the upper r keystream bits SHALL be used; the lower 8-r bits SHALL be zero, passing those plaintext bits through unchanged.
REQ-020 pt_ready SHALL be (state == ACTIVE) && (!ct_valid || ct_ready).
REQ-021 On a pt handshake the block SHALL register ct_data = pt_data ^ ks_byte(idx), set ct_valid = 1 and increment idx; ct_valid appears one cycle after acceptance.
REQ-022 ct_valid and ct_data SHALL hold stable while ct_valid && !ct_ready.
REQ-023 ct_valid SHALL clear on a ct handshake with no pt handshake in the same cycle.
REQ-024 A simultaneous ct handshake and pt handshake SHALL replace the output with the new byte, giving full throughput of one byte per cycle.
REQ-025 The pt handshake that consumes byte nbytes-1 SHALL move the FSM to EMPTY in the next cycle; the next block may be accepted while the final ct byte is still pending.
REQ-026 busy SHALL be (state == ACTIVE).
REQ-027 ks_valid SHALL be ignored while ACTIVE; no block is dropped or overwritten.

Reset
REQ-028 On reset the block SHALL set state = EMPTY, idx = 0, nbytes = 0, ct_valid = 0, ct_data = 0, busy = 0, ks_ready = 1 and pt_ready = 0.
REQ-029 Reset mid-block SHALL discard the held keystream and any pending ct byte, with no output on the cycle after reset.

Configuration
REQ-030 With KSX_BYTE_CNT_EN defined, the block SHALL add output byte_cnt[31:0], reset to 0, incremented on every ct handshake and wrapping 0xFFFFFFFF -> 0.
REQ-031 Without KSX_BYTE_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Full block with a counting pattern: ks_block bytes 0x00..0x3F, ks_len = 512, pt = 0xFF x64, ct_ready = 1 -> ct = 0xFF^k for k = 0..63 on 64 consecutive cycles, then ks_ready = 1.
REQ-033 Partial length: ks_len = 12, ks_block[511:496] = 0xABCD, pt = 0x00, 0x00 -> ct = 0xAB then 0xC0; state EMPTY after the 2nd accept.
REQ-034 Backpressure: ct_ready low for 5 cycles after the first byte -> ct_data stable, pt_ready = 0, no byte lost, and order is preserved on release.
REQ-035 Edge lengths: ks_len = 0 -> ks_ready stays 1 and no ct output; ks_len = 4000 -> exactly 64 bytes emitted.
REQ-036 Reset asserted after byte 10 of 64 -> next cycle ct_valid = 0, busy = 0, ks_ready = 1; a new block starts at byte 0.
REQ-037 With KSX_BYTE_CNT_EN: after two full 512-bit blocks, byte_cnt = 128; force-preload 0xFFFFFFFF plus one handshake -> byte_cnt = 0.
